// File: rtl/calc_input_ctrl_if.sv
// Keypad-to-ALU bus for calc_input_ctrl.
//   key_valid/key_code : one-cycle key strobe from the keypad decoder
//   res                : BCD result returned by the ALU (16'hFBAB = NaN)
//   num1/num2/op/exe   : operands, operator and execute strobe to the ALU
//   display/busy       : BCD value to show, and sequencer-busy flag
// The master modport is the sequencer; the slave modport is its environment.
interface calc_input_ctrl_if;
   localparam int unsigned BCD_W = 16;
   localparam int unsigned KEY_W = 4;

   logic             key_valid;
   logic [KEY_W-1:0] key_code;
   logic [BCD_W-1:0] res;
   logic [BCD_W-1:0] num1;
   logic [BCD_W-1:0] num2;
   logic [KEY_W-1:0] op;
   logic             exe;
   logic [BCD_W-1:0] display;
   logic             busy;

   modport master (
      input  key_valid, key_code, res,
      output num1, num2, op, exe, display, busy
   );

   modport slave (
      output key_valid, key_code, res,
      input  num1, num2, op, exe, display, busy
   );
endinterface

// File: rtl/calc_input_ctrl.sv
// Keypad-side sequencer for the calculator ALU: assembles two 4-digit BCD
// operands and an operator from key strobes, pulses exe for EXE_CYCLES
// cycles, then captures the ALU result for display and chained operations.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : calc_input_ctrl_if master (key strobe in, ALU/display out)
module calc_input_ctrl #(
   parameter int unsigned EXE_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   calc_input_ctrl_if.master   bus
);

   localparam int unsigned BCD_W = 16;
   localparam int unsigned KEY_W = 4;
   localparam int unsigned DIG_W = 3;
   localparam int unsigned ECNT_W = (EXE_CYCLES > 1) ? $clog2(EXE_CYCLES) : 1;

   localparam logic [KEY_W-1:0] KEY_EQ   = KEY_W'(10);
   localparam logic [KEY_W-1:0] KEY_CLR  = KEY_W'(11);
   localparam logic [KEY_W-1:0] KEY_PLUS = KEY_W'(12);
   localparam logic [BCD_W-1:0] NAN_VAL  = 16'hFBAB;
   localparam logic [DIG_W-1:0] MAX_DIG  = DIG_W'(4);

   typedef enum logic [2:0] {
      S_ENTER1,
      S_ENTER2,
      S_EXEC,
      S_WAIT,
      S_SHOW
   } state_t;

   state_t            state;
   logic [DIG_W-1:0]  cnt1;
   logic [DIG_W-1:0]  cnt2;
   logic [ECNT_W-1:0] ecnt;
   logic [BCD_W-1:0]  rreg;

   logic key_digit;
   logic key_oper;
   logic key_eq;
   logic key_clr;

   // Key classification; every class is gated by the strobe.
   assign key_digit = bus.key_valid && (bus.key_code < KEY_W'(10));
   assign key_oper  = bus.key_valid && (bus.key_code >= KEY_PLUS);
   assign key_eq    = bus.key_valid && (bus.key_code == KEY_EQ);
   assign key_clr   = bus.key_valid && (bus.key_code == KEY_CLR);

   // Sequencer; display is kept in step with the state so it is registered.
   always_ff @(posedge clk) begin
      if (rst || key_clr) begin
         state       <= S_ENTER1;
         cnt1        <= '0;
         cnt2        <= '0;
         ecnt        <= '0;
         rreg        <= '0;
         bus.num1    <= '0;
         bus.num2    <= '0;
         bus.op      <= KEY_PLUS;
         bus.exe     <= 1'b0;
         bus.display <= '0;
         bus.busy    <= 1'b0;
      end else begin
         case (state)
            S_ENTER1: begin
               if (key_digit) begin
                  if (cnt1 < MAX_DIG) begin
                     bus.num1    <= {bus.num1[11:0], bus.key_code};
                     bus.display <= {bus.num1[11:0], bus.key_code};
                     cnt1        <= cnt1 + DIG_W'(1);
                  end
               end else if (key_oper) begin
                  bus.op      <= bus.key_code;
                  bus.num2    <= '0;
                  cnt2        <= '0;
                  bus.display <= bus.num1;
                  state       <= S_ENTER2;
               end
            end

            S_ENTER2: begin
               if (key_digit) begin
                  if (cnt2 < MAX_DIG) begin
                     bus.num2    <= {bus.num2[11:0], bus.key_code};
                     bus.display <= {bus.num2[11:0], bus.key_code};
                     cnt2        <= cnt2 + DIG_W'(1);
                  end
               end else if (key_oper) begin
                  // Operator may only be changed before operand 2 starts.
                  if (cnt2 == '0) begin
                     bus.op <= bus.key_code;
                  end
               end else if (key_eq) begin
                  if (cnt2 != '0) begin
                     ecnt     <= '0;
                     bus.exe  <= 1'b1;
                     bus.busy <= 1'b1;
                     state    <= S_EXEC;
                  end
               end
            end

            S_EXEC: begin
               if (ecnt == ECNT_W'(EXE_CYCLES - 1)) begin
                  bus.exe <= 1'b0;
                  state   <= S_WAIT;
               end else begin
                  ecnt <= ecnt + ECNT_W'(1);
               end
            end

            S_WAIT: begin
               // Give the ALU one quiet cycle, then latch its result.
               rreg        <= bus.res;
               bus.display <= bus.res;
               bus.busy    <= 1'b0;
               state       <= S_SHOW;
            end

            S_SHOW: begin
               if (key_digit) begin
                  bus.num1    <= {12'h000, bus.key_code};
                  bus.display <= {12'h000, bus.key_code};
                  cnt1        <= DIG_W'(1);
                  state       <= S_ENTER1;
               end else if (key_oper && (rreg != NAN_VAL)) begin
                  // Chain: previous result becomes a full operand 1.
                  bus.num1    <= rreg;
                  cnt1        <= MAX_DIG;
                  bus.op      <= bus.key_code;
                  bus.num2    <= '0;
                  cnt2        <= '0;
                  bus.display <= rreg;
                  state       <= S_ENTER2;
               end
            end

            default: begin
               state <= S_ENTER1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_calc_input_ctrl.sv
// Self-checking bench for calc_input_ctrl with a behavioural BCD ALU.
module tb_calc_input_ctrl;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   int   exe_rises;

   calc_input_ctrl_if bus ();

   calc_input_ctrl #(.EXE_CYCLES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int bcd2int(input logic [15:0] b);
      return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic logic [15:0] int2bcd(input int v);
      logic [15:0] r;
      int          t;
      t = v;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Behavioural ALU: computes on the rising edge of exe.
   always @(posedge bus.exe) begin
      int a;
      int b;
      int r;
      logic nan;
      exe_rises = exe_rises + 1;
      a   = bcd2int(bus.num1);
      b   = bcd2int(bus.num2);
      nan = 1'b0;
      r   = 0;
      case (bus.op)
         4'd12:   r = a + b;
         4'd13:   r = a - b;
         4'd14:   r = a * b;
         default: begin
            if (b == 0) nan = 1'b1;
            else        r = a / b;
         end
      endcase
      if (r < 0 || r > 9999) nan = 1'b1;
      bus.res = nan ? 16'hFBAB : int2bcd(r);
   end

   task automatic press(input logic [3:0] c);
      @(negedge clk);
      bus.key_valid = 1'b1;
      bus.key_code  = c;
      @(negedge clk);
      bus.key_valid = 1'b0;
   endtask

   // Strobe equals, optionally inject one key in the first EXEC cycle, and
   // record exe/busy for cycles t+1..t+5 plus display at t+4.
   task automatic do_equals(input logic inject, input logic [3:0] icode,
                            output logic [4:0] eh, output logic [4:0] bh,
                            output logic [15:0] disp4);
      @(negedge clk);
      bus.key_valid = 1'b1;
      bus.key_code  = 4'd10;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 0) begin
            bus.key_valid = inject;
            bus.key_code  = icode;
         end else begin
            bus.key_valid = 1'b0;
         end
         eh[k] = bus.exe;
         bh[k] = bus.busy;
         if (k == 3) disp4 = bus.display;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({bus.num1, bus.num2, bus.display} !== 48'h0) begin
         n_fail++;
         $display("FAIL reset_data: got num1=%h num2=%h display=%h, want all 0000", bus.num1, bus.num2, bus.display);
      end
      n_checks++;
      if (bus.op !== 4'd12 || bus.exe !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got op=%0d exe=%b busy=%b, want op=12 exe=0 busy=0", bus.op, bus.exe, bus.busy);
      end
   endtask

   task automatic test_add();
      logic [4:0]  eh;
      logic [4:0]  bh;
      logic [15:0] d4;
      int          r0;
      press(4'd1); press(4'd2); press(4'd3);
      n_checks++;
      if (bus.num1 !== 16'h0123 || bus.display !== 16'h0123) begin
         n_fail++;
         $display("FAIL add_num1: got num1=%h display=%h, want 0123/0123", bus.num1, bus.display);
      end
      press(4'd12);
      n_checks++;
      if (bus.op !== 4'd12 || bus.num2 !== 16'h0 || bus.display !== 16'h0123) begin
         n_fail++;
         $display("FAIL add_op: got op=%0d num2=%h display=%h, want 12/0000/0123", bus.op, bus.num2, bus.display);
      end
      press(4'd4); press(4'd5);
      n_checks++;
      if (bus.num2 !== 16'h0045 || bus.display !== 16'h0045) begin
         n_fail++;
         $display("FAIL add_num2: got num2=%h display=%h, want 0045/0045", bus.num2, bus.display);
      end
      r0 = exe_rises;
      do_equals(1'b0, 4'd0, eh, bh, d4);
      n_checks++;
      if (eh !== 5'b00011 || bh !== 5'b00111) begin
         n_fail++;
         $display("FAIL add_timing: got exe=%b busy=%b, want 00011/00111", eh, bh);
      end
      n_checks++;
      if (d4 !== 16'h0168 || exe_rises - r0 !== 1) begin
         n_fail++;
         $display("FAIL add_result: got display=%h rises=%0d, want 0168/1", d4, exe_rises - r0);
      end
   endtask

   task automatic test_chain();
      logic [4:0]  eh;
      logic [4:0]  bh;
      logic [15:0] d4;
      press(4'd13);
      n_checks++;
      if (bus.num1 !== 16'h0168 || bus.op !== 4'd13 || bus.num2 !== 16'h0 || bus.display !== 16'h0168) begin
         n_fail++;
         $display("FAIL chain_op: got num1=%h op=%0d num2=%h display=%h, want 0168/13/0000/0168",
                  bus.num1, bus.op, bus.num2, bus.display);
      end
      press(4'd8);
      do_equals(1'b0, 4'd0, eh, bh, d4);
      n_checks++;
      if (bus.num2 !== 16'h0008 || d4 !== 16'h0160 || eh !== 5'b00011) begin
         n_fail++;
         $display("FAIL chain_result: got num2=%h display=%h exe=%b, want 0008/0160/00011", bus.num2, d4, eh);
      end
   endtask

   task automatic test_fifth_digit();
      press(4'd1);
      n_checks++;
      if (bus.num1 !== 16'h0001 || bus.display !== 16'h0001) begin
         n_fail++;
         $display("FAIL show_digit: got num1=%h display=%h, want 0001/0001", bus.num1, bus.display);
      end
      press(4'd2); press(4'd3); press(4'd4); press(4'd5);
      n_checks++;
      if (bus.num1 !== 16'h1234 || bus.display !== 16'h1234) begin
         n_fail++;
         $display("FAIL fifth_digit: got num1=%h display=%h, want 1234/1234", bus.num1, bus.display);
      end
   endtask

   task automatic test_div_zero();
      logic [4:0]  eh;
      logic [4:0]  bh;
      logic [15:0] d4;
      press(4'd11);
      press(4'd9); press(4'd15); press(4'd0);
      do_equals(1'b0, 4'd0, eh, bh, d4);
      n_checks++;
      if (d4 !== 16'hFBAB || bus.display !== 16'hFBAB) begin
         n_fail++;
         $display("FAIL div_zero: got display=%h/%h, want fbab", d4, bus.display);
      end
      press(4'd12);
      n_checks++;
      if (bus.display !== 16'hFBAB || bus.op !== 4'd15 || bus.num1 !== 16'h0009) begin
         n_fail++;
         $display("FAIL nan_op_ignored: got display=%h op=%0d num1=%h, want fbab/15/0009", bus.display, bus.op, bus.num1);
      end
      press(4'd7);
      n_checks++;
      if (bus.num1 !== 16'h0007 || bus.display !== 16'h0007) begin
         n_fail++;
         $display("FAIL nan_digit: got num1=%h display=%h, want 0007/0007", bus.num1, bus.display);
      end
   endtask

   task automatic test_op_replace();
      press(4'd10);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.display !== 16'h0007) begin
         n_fail++;
         $display("FAIL eq_in_enter1: got busy=%b display=%h, want 0/0007", bus.busy, bus.display);
      end
      press(4'd12); press(4'd13);
      n_checks++;
      if (bus.op !== 4'd13) begin
         n_fail++;
         $display("FAIL op_replace: got op=%0d, want 13", bus.op);
      end
      press(4'd10);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.exe !== 1'b0 || bus.display !== 16'h0007) begin
         n_fail++;
         $display("FAIL eq_no_num2: got busy=%b exe=%b display=%h, want 0/0/0007", bus.busy, bus.exe, bus.display);
      end
      press(4'd6); press(4'd12);
      n_checks++;
      if (bus.op !== 4'd13 || bus.num2 !== 16'h0006) begin
         n_fail++;
         $display("FAIL op_after_num2: got op=%0d num2=%h, want 13/0006", bus.op, bus.num2);
      end
   endtask

   task automatic test_exec_keys();
      logic [4:0]  eh;
      logic [4:0]  bh;
      logic [15:0] d4;
      int          r0;
      press(4'd11);
      press(4'd2); press(4'd12); press(4'd3);
      r0 = exe_rises;
      do_equals(1'b1, 4'd5, eh, bh, d4);
      n_checks++;
      if (bus.num2 !== 16'h0003 || d4 !== 16'h0005) begin
         n_fail++;
         $display("FAIL exec_digit: got num2=%h display=%h, want 0003/0005", bus.num2, d4);
      end
      n_checks++;
      if (eh !== 5'b00011 || bh !== 5'b00111 || exe_rises - r0 !== 1) begin
         n_fail++;
         $display("FAIL exec_digit_exe: got exe=%b busy=%b rises=%0d, want 00011/00111/1", eh, bh, exe_rises - r0);
      end
   endtask

   task automatic test_clear_exec();
      logic [4:0]  eh;
      logic [4:0]  bh;
      logic [15:0] d4;
      press(4'd11);
      press(4'd2); press(4'd12); press(4'd3);
      do_equals(1'b1, 4'd11, eh, bh, d4);
      n_checks++;
      if (eh !== 5'b00001 || bh !== 5'b00001) begin
         n_fail++;
         $display("FAIL clear_exec_timing: got exe=%b busy=%b, want 00001/00001", eh, bh);
      end
      n_checks++;
      if (d4 !== 16'h0 || bus.display !== 16'h0 || bus.num1 !== 16'h0 || bus.num2 !== 16'h0 || bus.op !== 4'd12) begin
         n_fail++;
         $display("FAIL clear_exec_state: got display=%h num1=%h num2=%h op=%0d, want 0000/0000/0000/12",
                  bus.display, bus.num1, bus.num2, bus.op);
      end
      press(4'd4);
      n_checks++;
      if (bus.num1 !== 16'h0004 || bus.display !== 16'h0004) begin
         n_fail++;
         $display("FAIL clear_exec_enter1: got num1=%h display=%h, want 0004/0004", bus.num1, bus.display);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      exe_rises     = 0;
      rst           = 1'b1;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'd0;
      bus.res       = 16'h0;
      test_reset();
      test_add();
      test_chain();
      test_fifth_digit();
      test_div_zero();
      test_op_replace();
      test_exec_keys();
      test_clear_exec();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/calc_input_ctrl.md
# calc_input_ctrl

Keypad-side sequencer that feeds the calculator ALU. It takes one-cycle key strobes, assembles the two 4-digit BCD operands and the operator, and drives `exe` for a fixed number of cycles. It then captures the ALU's BCD result for display and for chained operations. It sits between the keypad decoder and the ALU: it initiates each ALU operation, and the ALU responds to it.

## Interface
- `EXE_CYCLES`, default 2: cycles `exe` is held high per operation (≥1).
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_valid` in 1: one-cycle key strobe.
- `key_code` in 4: 0–9 digit, 10 equals, 11 clear, 12 plus, 13 minus, 14 mult, 15 div.
- `res` in 16: ALU BCD result; 16'hFBAB = NaN.
- `num1` out 16: BCD operand 1 to ALU.
- `num2` out 16: BCD operand 2 to ALU.
- `op` out 4: operator to ALU (12–15).
- `exe` out 1: ALU execute; the ALU acts on its rising edge.
- `display` out 16: BCD value to show.
- `busy` out 1: high in EXEC/WAIT; keys are ignored then, except clear.

## Operation
- All outputs are registered.
- Reset values:
  - `num1`=0, `num2`=0, `op`=12, `exe`=0, `display`=0, `busy`=0.
  - State ENTER1; digit counters `cnt1`=`cnt2`=0; result register `rreg`=0.
- A digit is accepted only if its counter is <4: `numX` <= {`numX`[11:0], d} and `cntX`++. A 5th digit is ignored.
- Clear (11) in any state, including EXEC/WAIT, gives the reset state next cycle. `exe` drops immediately.
- Codes 10–15 never enter a number.
- ENTER1:
  - Digit: append to `num1`.
  - Operator: `op`<=key, `num2`<=0, `cnt2`<=0, go to ENTER2.
  - Equals: ignored.
- ENTER2:
  - Digit: append to `num2`.
  - Operator with `cnt2`==0: replaces `op`.
  - Operator with `cnt2`>0: ignored.
  - Equals with `cnt2`==0: ignored.
  - Equals with `cnt2`>0: go to EXEC.
- EXEC:
  - `exe`=1 and `busy`=1 for EXE_CYCLES cycles, counted by an internal counter.
  - Then go to WAIT.
- WAIT:
  - `exe`=0, `busy`=1 for one cycle.
  - At the end of that cycle, `rreg`<=`res`, then go to SHOW.
- SHOW:
  - Digit d: `num1`<={12'h000,d}, `cnt1`<=1, go to ENTER1.
  - Operator, `rreg`≠FBAB: `num1`<=`rreg`, `cnt1`<=4, `op`<=key, `num2`<=0, `cnt2`<=0, go to ENTER2.
  - Operator, `rreg`==FBAB: ignored.
  - Equals: ignored.
- `display` by state:
  - ENTER1: `num1`.
  - ENTER2: `num2` if `cnt2`>0, else `num1`.
  - EXEC/WAIT: `num2`.
  - SHOW: `rreg`.
- Operands and `op` are stable from the EXEC entry until SHOW is left.
- No arithmetic is done in this block; the BCD digits are passed through unmodified.

## Timing
- A key strobe sampled at edge t takes effect in the registers after edge t; outputs show it in cycle t+1.
- Equals accepted in cycle t:
  - `exe`=1 in cycles t+1 … t+EXE_CYCLES.
  - `exe`=0 in cycle t+EXE_CYCLES+1 (WAIT).
  - `display`=`res` from cycle t+EXE_CYCLES+2.
  - `busy`=1 in cycles t+1 … t+EXE_CYCLES+1.
- `exe` has exactly one rising edge per accepted equals. It never glitches, because it is a register output.
- A key during `busy` (other than clear) is dropped, not queued.
- If clear and equals could coincide, clear has priority. Only one key per strobe exists.
- Reset asserted mid-EXEC: `exe`=0 the next cycle, and the ALU result is discarded.

## Test plan
- Reset: hold `rst` 2 cycles → all outputs 0 except `op`=12; state ENTER1; `busy`=0.
- Keys 1,2,3,12,4,5,10 with a behavioural ALU model:
  - `num1`=16'h0123, `op`=12, `num2`=16'h0045.
  - `exe` high for exactly 2 cycles.
  - `display`=16'h0168 at equals+4 cycles; `busy` high 3 cycles.
- Keys 1,2,3,4,5 → `num1`=16'h1234; `display`=16'h1234.
- Chain from a 16'h0168 result: keys 13, 8, 10 → `num1`=16'h0168, `op`=13, `num2`=16'h0008, `display`=16'h0160.
- Divide by zero: keys 9,15,0,10 → `display`=16'hFBAB. Then key 12 is ignored (state SHOW). Then key 7 → `num1`=16'h0007 in ENTER1.
- Keys during EXEC:
  - Digit 5 during EXEC: `num2` unchanged, no extra `exe` edge.
  - Clear during EXEC: `exe`=0 next cycle; reset values restored; no result captured.
